// File: rtl/move_counter_if.sv
// Handshake bundle for move_counter: step request and controls in, registered count and event flags out.
interface move_counter_if #(
  parameter int WIDTH = 8
);
  logic             move;
  logic             dir;
  logic             wrap_en;
  logic             clear;
  logic [WIDTH-1:0] count;
  logic             at_max;
  logic             at_min;
  logic             wrap;
  logic             sat;

  modport master (
    output move, dir, wrap_en, clear,
    input  count, at_max, at_min, wrap, sat
  );

  modport slave (
    input  move, dir, wrap_en, clear,
    output count, at_max, at_min, wrap, sat
  );
endinterface

// File: rtl/move_counter.sv
// Up/down step counter over 0..MAX_COUNT with wrap or saturate at the limits and one-cycle event pulses.
// Optional macro MOVE_COUNTER_EDGE_EN turns the move request into a rising-edge qualified step.
module move_counter #(
  parameter int WIDTH     = 8,
  parameter int MAX_COUNT = 4
) (
  input logic           clk,
  input logic           rst,
  move_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  generate
    if (WIDTH < 1 || MAX_COUNT < 1 ||
        (WIDTH < 63 && longint'(MAX_COUNT) > ((longint'(1) << WIDTH) - 1))) begin : g_bad_param
      $error("move_counter: MAX_COUNT %0d out of range for WIDTH %0d", MAX_COUNT, WIDTH);
    end
  endgenerate

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_r;
  logic             wrap_nxt;
  logic             sat_r;
  logic             sat_nxt;
  logic             step;

`ifdef MOVE_COUNTER_EDGE_EN
  // move_q resets high so a request held through reset release does not count.
  logic move_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      move_q <= 1'b1;
    end else begin
      move_q <= bus.move;
    end
  end

  assign step = bus.move & ~move_q;
`else
  assign step = bus.move;
`endif

  always_comb begin
    count_nxt = count_r;
    wrap_nxt  = 1'b0;
    sat_nxt   = 1'b0;
    if (bus.clear) begin
      count_nxt = '0;
    end else if (count_r > MAX_C) begin
      // Out-of-range value can only come from upset; recover to zero.
      count_nxt = '0;
    end else if (step) begin
      if (!bus.dir) begin
        if (count_r != MAX_C) begin
          count_nxt = count_r + ONE;
        end else if (bus.wrap_en) begin
          count_nxt = '0;
          wrap_nxt  = 1'b1;
        end else begin
          sat_nxt   = 1'b1;
        end
      end else begin
        if (count_r != '0) begin
          count_nxt = count_r - ONE;
        end else if (bus.wrap_en) begin
          count_nxt = MAX_C;
          wrap_nxt  = 1'b1;
        end else begin
          sat_nxt   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
      wrap_r  <= 1'b0;
      sat_r   <= 1'b0;
    end else begin
      count_r <= count_nxt;
      wrap_r  <= wrap_nxt;
      sat_r   <= sat_nxt;
    end
  end

  assign bus.count  = count_r;
  assign bus.at_max = (count_r == MAX_C);
  assign bus.at_min = (count_r == '0);
  assign bus.wrap   = wrap_r;
  assign bus.sat    = sat_r;

endmodule

// File: tb/tb_move_counter.sv
// Self-checking bench for move_counter: directed vector table, hand-written corner sequences,
// and randomized stimulus against a behavioural position model. Honours MOVE_COUNTER_EDGE_EN.
module tb_move_counter;
  localparam int WIDTH = 8;
  localparam int MAXC  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  move_counter_if #(.WIDTH(WIDTH)) bus ();

  move_counter #(.WIDTH(WIDTH), .MAX_COUNT(MAXC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic mv, dr, we, cl;
    int   cnt;
    logic wr, st, amax, amin;
  } vec_t;
  vec_t tbl[$];

  int m_count;
  bit m_wrap, m_sat;
`ifdef MOVE_COUNTER_EDGE_EN
  bit m_prev;
`endif

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string name, input int cnt, input bit wr, input bit st);
    check({name, ".count"},  int'(bus.count),  cnt);
    check({name, ".wrap"},   int'(bus.wrap),   int'(wr));
    check({name, ".sat"},    int'(bus.sat),    int'(st));
    check({name, ".at_max"}, int'(bus.at_max), int'(cnt == MAXC));
    check({name, ".at_min"}, int'(bus.at_min), int'(cnt == 0));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit mv, input bit dr, input bit we, input bit cl);
    bus.move    = mv;
    bus.dir     = dr;
    bus.wrap_en = we;
    bus.clear   = cl;
  endtask

  task automatic add(input bit mv, dr, we, cl, input int cnt, input bit wr, st);
    vec_t v;
    v.mv = mv; v.dr = dr; v.we = we; v.cl = cl;
    v.cnt = cnt; v.wr = wr; v.st = st;
    v.amax = (cnt == MAXC); v.amin = (cnt == 0);
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    m_count = 0;
    m_wrap  = 0;
    m_sat   = 0;
`ifdef MOVE_COUNTER_EDGE_EN
    m_prev  = 1;
`endif
  endtask

  // One step with move dropped afterwards, so it counts once in both modes.
  task automatic pulse(input bit dr, input bit we);
    drive(1, dr, we, 0);
    cyc();
    drive(0, dr, we, 0);
    cyc();
  endtask

  // Position model: signed next position, then fold into range or block.
  task automatic model_step(input bit mv, input bit dr, input bit we, input bit cl);
    bit s;
    int nxt;
`ifdef MOVE_COUNTER_EDGE_EN
    s = mv && !m_prev;
    m_prev = mv;
`else
    s = mv;
`endif
    m_wrap = 0;
    m_sat  = 0;
    if (cl) begin
      m_count = 0;
    end else if (s) begin
      nxt = m_count + (dr ? -1 : 1);
      if (nxt >= 0 && nxt <= MAXC) m_count = nxt;
      else if (we) begin
        m_count = (nxt + MAXC + 1) % (MAXC + 1);
        m_wrap  = 1;
      end else m_sat = 1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(0, 0, 0, 0);
    cyc();
    check_all("reset", 0, 0, 0);
    do_reset();

`ifndef MOVE_COUNTER_EDGE_EN
    // level wrap
    add(1,0,1,0, 1,0,0); add(1,0,1,0, 2,0,0); add(1,0,1,0, 3,0,0);
    add(1,0,1,0, 4,0,0); add(1,0,1,0, 0,1,0); add(1,0,1,0, 1,0,0);
    add(0,0,0,1, 0,0,0);
    // saturate up
    add(1,0,0,0, 1,0,0); add(1,0,0,0, 2,0,0); add(1,0,0,0, 3,0,0);
    add(1,0,0,0, 4,0,0); add(1,0,0,0, 4,0,1); add(1,0,0,0, 4,0,1);
    add(1,0,0,0, 4,0,1); add(0,0,0,0, 4,0,0);
    // clear beats a saturating step
    add(1,0,0,1, 0,0,0);
    // down limits
    add(1,1,1,0, 4,1,0); add(1,0,1,0, 0,1,0); add(1,1,0,0, 0,0,1);
    add(0,1,0,0, 0,0,0);
    // clear vs step, then controls changing while idle
    add(1,0,1,0, 1,0,0); add(1,0,1,0, 2,0,0); add(1,0,1,0, 3,0,0);
    add(1,0,1,1, 0,0,0); add(1,0,1,0, 1,0,0);
    add(0,1,0,0, 1,0,0); add(0,0,1,0, 1,0,0); add(1,1,0,0, 0,0,0);
    foreach (tbl[i]) begin
      drive(tbl[i].mv, tbl[i].dr, tbl[i].we, tbl[i].cl);
      cyc();
      check($sformatf("vec%0d.count", i), int'(bus.count), tbl[i].cnt);
      check($sformatf("vec%0d.wrap", i),  int'(bus.wrap),  int'(tbl[i].wr));
      check($sformatf("vec%0d.sat", i),   int'(bus.sat),   int'(tbl[i].st));
      check($sformatf("vec%0d.at_max", i), int'(bus.at_max), int'(tbl[i].amax));
      check($sformatf("vec%0d.at_min", i), int'(bus.at_min), int'(tbl[i].amin));
    end
`else
    // edge mode: held move counts once
    drive(0, 0, 1, 0);
    cyc();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 1, 0);
      cyc();
      check_all($sformatf("edge_hold%0d", i), 1, 0, 0);
    end
    drive(0, 0, 1, 0);
    cyc();
    check_all("edge_drop", 1, 0, 0);
    drive(1, 0, 1, 0);
    cyc();
    check_all("edge_rise", 2, 0, 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_all($sformatf("edge_held_rst%0d", i), 0, 0, 0);
    end
    drive(0, 0, 1, 0);
    cyc();
    pulse(0, 1);
    check_all("edge_after_rst", 1, 0, 0);
    drive(1, 0, 1, 1);
    cyc();
    check_all("edge_clear", 0, 0, 0);
    drive(0, 0, 1, 0);
    cyc();
`endif

    // async reset between edges, then resume from zero
    do_reset();
    drive(0, 0, 1, 0);
    cyc();
    pulse(0, 1);
    pulse(0, 1);
    check_all("pre_rst", 2, 0, 0);
    #3 rst = 1'b1;
    #1 check_all("async_rst_count", 0, 0, 0);
    cyc();
    rst = 1'b0;
    pulse(0, 1);
    check_all("resume", 1, 0, 0);
    pulse(1, 1);
    drive(1, 1, 1, 0);
    cyc();
    check_all("wrap_before_rst", 4, 1, 0);
    #3 rst = 1'b1;
    #1 check_all("async_rst_wrap", 0, 0, 0);
    cyc();
    rst = 1'b0;
    drive(0, 1, 0, 0);
    cyc();
    drive(1, 1, 0, 0);
    cyc();
    check_all("sat_before_rst", 0, 0, 1);
    #3 rst = 1'b1;
    #1 check_all("async_rst_sat", 0, 0, 0);
    drive(0, 0, 0, 0);

    // random against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bit mv, dr, we, cl;
      mv = ($urandom_range(0, 9) < 7);
      dr = ($urandom_range(0, 9) < 4);
      we = $urandom_range(0, 1);
      cl = ($urandom_range(0, 19) == 0);
      drive(mv, dr, we, cl);
      model_step(mv, dr, we, cl);
      cyc();
      check_all($sformatf("rand%0d", i), m_count, m_wrap, m_sat);
      total++;
      if (bus.wrap && bus.sat) begin
        bad++;
        $display("FAIL rand%0d.exclusive: got wrap=1 sat=1 expected not both", i);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/move_counter.md
# move_counter

Parametrised step counter driven by a single-bit move request, for the board-level movement and position logic. It counts between 0 and a configurable MAX_COUNT in either direction. At the limits it either wraps around or saturates, and it reports limit flags and one-cycle wrap and saturation event pulses. It sits between the debounced user-input path and the position and display logic.

## Interface
- WIDTH, 8, counter width in bits; must be ≥ 1.
- MAX_COUNT, 4, highest count value; 1 ≤ MAX_COUNT ≤ 2^WIDTH−1. An elaboration-time check fails on violation.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- move  in  1  step request; qualified per the Configuration section.
- dir  in  1  step direction: 0 = up (+1), 1 = down (−1).
- wrap_en  in  1  limit behaviour: 1 = wrap around, 0 = saturate.
- clear  in  1  synchronous clear of count to 0.
- count  out  WIDTH  current count, registered.
- at_max  out  1  count == MAX_COUNT; decoded from the register.
- at_min  out  1  count == 0; decoded from the register.
- wrap  out  1  registered pulse, high for the one cycle after a wrap step.
- sat  out  1  registered pulse, high for the one cycle after a step blocked at a limit.

## Operation
- Registers: count, wrap, sat, and move_q (move_q exists only under the edge macro).
- `step` is the qualified move request for the current cycle. It is defined in the Configuration section.
- Priority at each rising edge is rst, then clear, then step.
- **rst high:** count=0, wrap=0, sat=0, move_q=1, immediately and asynchronously.
- **clear high:** count←0, wrap←0, sat←0. Any step in the same cycle is discarded.
- **step with dir=0:**
  - count < MAX_COUNT: count←count+1.
  - count == MAX_COUNT and wrap_en=1: count←0, wrap←1.
  - count == MAX_COUNT and wrap_en=0: count holds, sat←1.
- **step with dir=1:**
  - count > 0: count←count−1.
  - count == 0 and wrap_en=1: count←MAX_COUNT, wrap←1.
  - count == 0 and wrap_en=0: count holds, sat←1.
- **No step:** count holds, wrap←0, sat←0.
- **Defensive rule:** if count is ever > MAX_COUNT (unreachable), the next step or idle cycle loads 0.
- All arithmetic is WIDTH-bit unsigned. No carry or borrow is exposed.
- dir and wrap_en are sampled only on cycles where step is high. Changing them between steps has no effect.
- clear does not alter move_q.

## Timing
- Latency: a step sampled at edge N is visible on count after edge N, so 1 cycle.
- at_max and at_min follow count in the same cycle with no added register stage.
- wrap and sat are one cycle wide per event. Back-to-back events keep them high on consecutive cycles. Example: saturating with move held high gives sat high on every blocked cycle.
- wrap and sat are never high together.
- Reset values of all outputs:
  - count=0
  - at_max = (MAX_COUNT==0 is illegal) so 0
  - at_min=1
  - wrap=0
  - sat=0
- Reset released mid-operation: counting resumes from 0 on the first edge after rst falls.

## Configuration
- Macro: MOVE_COUNTER_EDGE_EN.
- **Defined:** step = move & ~move_q, with move_q←move on every edge. A held-high move produces exactly one step. Because move_q resets to 1, a move held high through reset release produces no step until move falls and rises again.
- **Undefined:** step = move (level mode). Every cycle with move high is a step. move_q is not implemented.

## Test plan
- **Level wrap:** defaults, macro off; reset, then move=1, dir=0, wrap_en=1 for 6 cycles → count 1,2,3,4,0,1. wrap is high only in the cycle count shows 0. at_max is high while count=4.
- **Saturate up:** wrap_en=0, move held high from 0 for 7 cycles → count 1,2,3,4,4,4,4. sat is high on the last 3 cycles. wrap stays 0.
- **Down limits:** from count=0 with dir=1: wrap_en=1 gives count 4 and a wrap pulse. Back at 0, wrap_en=0 gives count 0 with a sat pulse and at_min=1.
- **Clear vs step:** at count=3, assert clear=1 and move=1 in the same cycle → count 0, no wrap or sat pulse. The next move gives count 1.
- **Async reset mid-count:** at count=2, raise rst between edges → count=0, wrap=0, sat=0 before the next edge. Counting resumes from 0 after release.
- **Edge mode:** macro on; hold move high for 5 cycles → count goes 0→1 only. Drop move for 1 cycle, then raise it → count 2. Move held high across reset release → count stays 0.
